instr_fetch_unit: RTL and testbench

- Fetch stage directly upstream of decode and the immediate extender.
- Holds the program counter, issues one instruction-memory request at a time, and captures the returned word.
- Presents the word to decode together with its 7-bit opcode field and PC, using a valid/ready handshake.
- Accepts redirects (branch, jump, jalr) from execute and discards any stale in-flight fetch.

---
 rtl/instr_fetch_unit_if.sv | 37 +++
 rtl/instr_fetch_unit.sv | 120 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_if.sv
// ============================================================================
// instr_fetch_unit_if : instruction-memory, redirect and decode handshake bus
// Revision 1.0
// ============================================================================
`default_nettype none

interface instr_fetch_unit_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_gnt;
  logic          imem_rvalid;
  logic [DW-1:0] imem_rdata;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          instr_valid;
  logic          instr_ready;
  logic [DW-1:0] instr;
  logic [6:0]    opcode;
  logic [AW-1:0] pc;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, opcode, pc,
    input  imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc,
           instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, opcode, pc,
    output imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc,
           instr_ready
  );
endinterface

`default_nettype wire

// File: rtl/instr_fetch_unit.sv
// ============================================================================
// instr_fetch_unit : single-outstanding fetch stage with redirect/kill support
// Revision 1.0
// ============================================================================
`default_nettype none

module instr_fetch_unit #(
  parameter int            AW       = 32,
  parameter int            DW       = 32,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  instr_fetch_unit_if.master bus
);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] fetch_pc_q, fetch_pc_d;
  logic          kill_q, kill_d;
  logic [DW-1:0] instr_q, instr_d;
  logic [AW-1:0] pc_q, pc_d;

  logic          w_req;
  logic          w_valid;
  logic [AW-1:0] w_redir_pc;
  logic [AW-1:0] w_pc_inc;

  assign w_redir_pc = bus.redirect_pc & ~AW'(3);
  assign w_pc_inc   = pc_q + AW'(4);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_BOOT;
      fetch_pc_q <= RESET_PC;
      kill_q     <= 1'b0;
      instr_q    <= '0;
      pc_q       <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      kill_q     <= kill_d;
      instr_q    <= instr_d;
      pc_q       <= pc_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    kill_d     = kill_q;
    instr_d    = instr_q;
    pc_d       = pc_q;
    w_req      = 1'b0;
    w_valid    = 1'b0;

    unique case (state_q)
      S_BOOT: state_d = S_REQ;

      S_REQ: begin
        w_req = 1'b1;
        if (bus.redirect_valid) begin
          fetch_pc_d = w_redir_pc;
        end
        if (bus.imem_gnt) begin
          state_d = S_WAIT;
          // The granted address is already stale if execute redirects now.
          kill_d  = bus.redirect_valid;
        end
      end

      S_WAIT: begin
        if (bus.redirect_valid) begin
          fetch_pc_d = w_redir_pc;
        end
        if (bus.imem_rvalid) begin
          if (kill_q || bus.redirect_valid) begin
            kill_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            instr_d = bus.imem_rdata;
            pc_d    = fetch_pc_q;
            state_d = S_HOLD;
          end
        end else if (bus.redirect_valid) begin
          kill_d = 1'b1;
        end
      end

      S_HOLD: begin
        w_valid = ~bus.redirect_valid;
        if (bus.redirect_valid) begin
          fetch_pc_d = w_redir_pc;
          state_d    = S_REQ;
        end else if (bus.instr_ready) begin
          fetch_pc_d = w_pc_inc;
          state_d    = S_REQ;
        end
      end

      default: state_d = S_BOOT;
    endcase
  end

  assign bus.imem_req    = w_req;
  assign bus.imem_addr   = fetch_pc_q;
  assign bus.instr_valid = w_valid;
  assign bus.instr       = instr_q;
  assign bus.opcode      = instr_q[6:0];
  assign bus.pc          = pc_q;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
// ============================================================================
// tb_instr_fetch_unit : directed self-checking bench for instr_fetch_unit
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_instr_fetch_unit;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  instr_fetch_unit_if #(.AW(32), .DW(32)) bus ();

  instr_fetch_unit #(.AW(32), .DW(32), .RESET_PC(32'h0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.imem_gnt       = 1'b0;
    bus.imem_rvalid    = 1'b0;
    bus.imem_rdata     = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.instr_ready    = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    cyc();
    vectors++; if (bus.imem_req !== 1'b0) begin miscompares++; $display("FAIL rst_req: got %b expected 0", bus.imem_req); end
    vectors++; if (bus.instr_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid: got %b expected 0", bus.instr_valid); end
    vectors++; if (bus.instr !== 32'h0) begin miscompares++; $display("FAIL rst_instr: got %h expected 0", bus.instr); end
    vectors++; if (bus.opcode !== 7'h0) begin miscompares++; $display("FAIL rst_opcode: got %h expected 0", bus.opcode); end
    vectors++; if (bus.pc !== 32'h0) begin miscompares++; $display("FAIL rst_pc: got %h expected 0", bus.pc); end
    vectors++; if (bus.imem_addr !== 32'h0) begin miscompares++; $display("FAIL rst_addr: got %h expected 0", bus.imem_addr); end
    rst_n = 1'b1;
    #1;
    vectors++; if (bus.imem_req !== 1'b0) begin miscompares++; $display("FAIL boot_req: got %b expected 0", bus.imem_req); end
  endtask

  task automatic test_first_fetch();
    cyc();
    vectors++; if (bus.imem_req !== 1'b1) begin miscompares++; $display("FAIL ff_req: got %b expected 1", bus.imem_req); end
    vectors++; if (bus.imem_addr !== 32'h0) begin miscompares++; $display("FAIL ff_addr: got %h expected 0", bus.imem_addr); end
    bus.imem_gnt = 1'b1;
    bus.instr_ready = 1'b1;
    cyc();
    bus.imem_gnt = 1'b0;
    vectors++; if (bus.imem_req !== 1'b0) begin miscompares++; $display("FAIL ff_wait_req: got %b expected 0", bus.imem_req); end
    vectors++; if (bus.instr_valid !== 1'b0) begin miscompares++; $display("FAIL ff_wait_valid: got %b expected 0", bus.instr_valid); end
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'h00500093;
    cyc();
    bus.imem_rvalid = 1'b0;
    vectors++; if (bus.instr_valid !== 1'b1) begin miscompares++; $display("FAIL ff_valid: got %b expected 1", bus.instr_valid); end
    vectors++; if (bus.instr !== 32'h00500093) begin miscompares++; $display("FAIL ff_instr: got %h expected 00500093", bus.instr); end
    vectors++; if (bus.opcode !== 7'b0010011) begin miscompares++; $display("FAIL ff_opcode: got %b expected 0010011", bus.opcode); end
    vectors++; if (bus.pc !== 32'h0) begin miscompares++; $display("FAIL ff_pc: got %h expected 0", bus.pc); end
    cyc();
    bus.instr_ready = 1'b0;
    vectors++; if (bus.imem_req !== 1'b1) begin miscompares++; $display("FAIL ff_next_req: got %b expected 1", bus.imem_req); end
    vectors++; if (bus.imem_addr !== 32'h4) begin miscompares++; $display("FAIL ff_next_addr: got %h expected 4", bus.imem_addr); end
  endtask

  task automatic test_decode_stall();
    bus.imem_gnt = 1'b1;
    cyc();
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'h00A00113;
    cyc();
    bus.imem_rvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      // A stray response while holding must not disturb the held word.
      if (i == 2) begin
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'hFFFFFFFF;
      end else begin
        bus.imem_rvalid = 1'b0;
      end
      #1;
      vectors++; if (bus.instr_valid !== 1'b1) begin miscompares++; $display("FAIL stall_valid[%0d]: got %b expected 1", i, bus.instr_valid); end
      vectors++; if (bus.instr !== 32'h00A00113) begin miscompares++; $display("FAIL stall_instr[%0d]: got %h expected 00a00113", i, bus.instr); end
      vectors++; if (bus.opcode !== 7'h13) begin miscompares++; $display("FAIL stall_opcode[%0d]: got %h expected 13", i, bus.opcode); end
      vectors++; if (bus.pc !== 32'h4) begin miscompares++; $display("FAIL stall_pc[%0d]: got %h expected 4", i, bus.pc); end
      vectors++; if (bus.imem_req !== 1'b0) begin miscompares++; $display("FAIL stall_req[%0d]: got %b expected 0", i, bus.imem_req); end
      cyc();
    end
    bus.imem_rvalid = 1'b0;
    bus.instr_ready = 1'b1;
    cyc();
    bus.instr_ready = 1'b0;
    vectors++; if (bus.imem_req !== 1'b1) begin miscompares++; $display("FAIL stall_next_req: got %b expected 1", bus.imem_req); end
    vectors++; if (bus.imem_addr !== 32'h8) begin miscompares++; $display("FAIL stall_next_addr: got %h expected 8", bus.imem_addr); end
  endtask

  task automatic test_redirect_gnt();
    bus.imem_gnt       = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h40;
    cyc();
    bus.imem_gnt       = 1'b0;
    bus.redirect_valid = 1'b0;
    vectors++; if (bus.imem_req !== 1'b0) begin miscompares++; $display("FAIL rg_wait_req: got %b expected 0", bus.imem_req); end
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'hDEADBEEF;
    cyc();
    bus.imem_rvalid = 1'b0;
    vectors++; if (bus.instr_valid !== 1'b0) begin miscompares++; $display("FAIL rg_valid: got %b expected 0", bus.instr_valid); end
    vectors++; if (bus.imem_req !== 1'b1) begin miscompares++; $display("FAIL rg_req: got %b expected 1", bus.imem_req); end
    vectors++; if (bus.imem_addr !== 32'h40) begin miscompares++; $display("FAIL rg_addr: got %h expected 40", bus.imem_addr); end
    bus.imem_gnt = 1'b1;
    cyc();
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'h00000013;
    cyc();
    bus.imem_rvalid = 1'b0;
    vectors++; if (bus.instr_valid !== 1'b1) begin miscompares++; $display("FAIL rg_dvalid: got %b expected 1", bus.instr_valid); end
    vectors++; if (bus.pc !== 32'h40) begin miscompares++; $display("FAIL rg_pc: got %h expected 40", bus.pc); end
    vectors++; if (bus.instr !== 32'h00000013) begin miscompares++; $display("FAIL rg_instr: got %h expected 00000013", bus.instr); end
  endtask

  task automatic test_redirect_hold();
    // Leave the 0x40 word via redirect to 0xC, then redirect again from pc 12.
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hC;
    bus.instr_ready    = 1'b1;
    #1;
    vectors++; if (bus.instr_valid !== 1'b0) begin miscompares++; $display("FAIL rh1_valid: got %b expected 0", bus.instr_valid); end
    cyc();
    bus.redirect_valid = 1'b0;
    bus.instr_ready    = 1'b0;
    vectors++; if (bus.imem_addr !== 32'hC) begin miscompares++; $display("FAIL rh1_addr: got %h expected c", bus.imem_addr); end
    bus.imem_gnt = 1'b1;
    cyc();
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'h00C00193;
    cyc();
    bus.imem_rvalid = 1'b0;
    vectors++; if (bus.instr_valid !== 1'b1) begin miscompares++; $display("FAIL rh2_pre_valid: got %b expected 1", bus.instr_valid); end
    vectors++; if (bus.pc !== 32'hC) begin miscompares++; $display("FAIL rh2_pc: got %h expected c", bus.pc); end
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h202;
    bus.instr_ready    = 1'b1;
    #1;
    vectors++; if (bus.instr_valid !== 1'b0) begin miscompares++; $display("FAIL rh2_valid: got %b expected 0", bus.instr_valid); end
    cyc();
    bus.redirect_valid = 1'b0;
    bus.instr_ready    = 1'b0;
    vectors++; if (bus.imem_req !== 1'b1) begin miscompares++; $display("FAIL rh2_req: got %b expected 1", bus.imem_req); end
    vectors++; if (bus.imem_addr !== 32'h200) begin miscompares++; $display("FAIL rh2_addr: got %h expected 200", bus.imem_addr); end
  endtask

  task automatic test_redirect_wait();
    bus.imem_gnt = 1'b1;
    cyc();
    bus.imem_gnt       = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h103;
    cyc();
    bus.redirect_valid = 1'b0;
    vectors++; if (bus.imem_req !== 1'b0) begin miscompares++; $display("FAIL rw_req: got %b expected 0", bus.imem_req); end
    cyc();
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'hDEADBEEF;
    cyc();
    bus.imem_rvalid = 1'b0;
    vectors++; if (bus.instr_valid !== 1'b0) begin miscompares++; $display("FAIL rw_valid: got %b expected 0", bus.instr_valid); end
    vectors++; if (bus.imem_req !== 1'b1) begin miscompares++; $display("FAIL rw_next_req: got %b expected 1", bus.imem_req); end
    vectors++; if (bus.imem_addr !== 32'h100) begin miscompares++; $display("FAIL rw_addr: got %h expected 100", bus.imem_addr); end
  endtask

  task automatic test_reset_in_wait();
    bus.imem_gnt = 1'b1;
    cyc();
    bus.imem_gnt = 1'b0;
    rst_n = 1'b0;
    #1;
    vectors++; if (bus.imem_req !== 1'b0) begin miscompares++; $display("FAIL rw2_rst_req: got %b expected 0", bus.imem_req); end
    vectors++; if (bus.imem_addr !== 32'h0) begin miscompares++; $display("FAIL rw2_rst_addr: got %h expected 0", bus.imem_addr); end
    vectors++; if (bus.pc !== 32'h0) begin miscompares++; $display("FAIL rw2_rst_pc: got %h expected 0", bus.pc); end
    cyc();
    rst_n = 1'b1;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'hDEADBEEF;
    #1;
    vectors++; if (bus.imem_req !== 1'b0) begin miscompares++; $display("FAIL rw2_boot_req: got %b expected 0", bus.imem_req); end
    cyc();
    bus.imem_rvalid = 1'b0;
    vectors++; if (bus.instr_valid !== 1'b0) begin miscompares++; $display("FAIL rw2_valid: got %b expected 0", bus.instr_valid); end
    vectors++; if (bus.instr !== 32'h0) begin miscompares++; $display("FAIL rw2_instr: got %h expected 0", bus.instr); end
    vectors++; if (bus.imem_req !== 1'b1) begin miscompares++; $display("FAIL rw2_req: got %b expected 1", bus.imem_req); end
    vectors++; if (bus.imem_addr !== 32'h0) begin miscompares++; $display("FAIL rw2_addr: got %h expected 0", bus.imem_addr); end
  endtask

  task automatic test_back_to_back();
    bus.instr_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      vectors++; if (bus.imem_req !== 1'b1) begin miscompares++; $display("FAIL b2b_req[%0d]: got %b expected 1", i, bus.imem_req); end
      vectors++; if (bus.imem_addr !== 32'(i * 4)) begin miscompares++; $display("FAIL b2b_addr[%0d]: got %h expected %h", i, bus.imem_addr, i * 4); end
      bus.imem_gnt = 1'b1;
      cyc();
      bus.imem_gnt    = 1'b0;
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = 32'h00100013 + 32'(i << 20);
      cyc();
      bus.imem_rvalid = 1'b0;
      vectors++; if (bus.instr_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_valid[%0d]: got %b expected 1", i, bus.instr_valid); end
      vectors++; if (bus.pc !== 32'(i * 4)) begin miscompares++; $display("FAIL b2b_pc[%0d]: got %h expected %h", i, bus.pc, i * 4); end
      vectors++; if (bus.instr !== 32'h00100013 + 32'(i << 20)) begin miscompares++; $display("FAIL b2b_instr[%0d]: got %h expected %h", i, bus.instr, 32'h00100013 + 32'(i << 20)); end
      cyc();
    end
    bus.instr_ready = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_first_fetch();
    test_decode_stall();
    test_redirect_gnt();
    test_redirect_hold();
    test_redirect_wait();
    test_reset_in_wait();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
